// File: rtl/mc_cu_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, ALU codes,
// datapath mux selects, opcode/func values and the decoded-instruction flag set.
package mc_cu_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'b000,
        S_ID  = 3'b001,
        S_EXE = 3'b010,
        S_MEM = 3'b011,
        S_WB  = 3'b100
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;
    localparam logic [3:0] ALU_SLT = 4'b1000;

    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BR   = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_RS     = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;
    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010;
    localparam logic [5:0] F_SRA = 6'b000011;
    localparam logic [5:0] F_JR  = 6'b001000;
    localparam logic [5:0] F_SLT = 6'b101010;

    typedef struct packed {
        logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr, i_slt;
        logic i_addi, i_andi, i_ori, i_xori, i_slti, i_lw, i_sw;
        logic i_beq, i_bne, i_lui, i_j, i_jal;
    } instr_t;

endpackage

// File: rtl/mc_cu_dec.sv
// Combinational opcode/func decode into one-hot instruction flags; anything that
// sets no flag is reported as illegal.
import mc_cu_pkg::*;

module mc_cu_dec #(
    parameter int EXT_OPS = 0
) (
    input  logic [5:0] op,
    input  logic [5:0] func,
    output instr_t     ins,
    output logic       illegal
);

    localparam bit EXT = (EXT_OPS != 0);

    logic rtype;

    assign rtype = (op == OP_RTYPE);

    always_comb begin
        ins        = '0;
        ins.i_add  = rtype && (func == F_ADD);
        ins.i_sub  = rtype && (func == F_SUB);
        ins.i_and  = rtype && (func == F_AND);
        ins.i_or   = rtype && (func == F_OR);
        ins.i_xor  = rtype && (func == F_XOR);
        ins.i_sll  = rtype && (func == F_SLL);
        ins.i_srl  = rtype && (func == F_SRL);
        ins.i_sra  = rtype && (func == F_SRA);
        ins.i_jr   = rtype && (func == F_JR);
        ins.i_slt  = EXT && rtype && (func == F_SLT);
        ins.i_addi = (op == OP_ADDI);
        ins.i_andi = (op == OP_ANDI);
        ins.i_ori  = (op == OP_ORI);
        ins.i_xori = (op == OP_XORI);
        ins.i_slti = EXT && (op == OP_SLTI);
        ins.i_lw   = (op == OP_LW);
        ins.i_sw   = (op == OP_SW);
        ins.i_beq  = (op == OP_BEQ);
        ins.i_bne  = (op == OP_BNE);
        ins.i_lui  = (op == OP_LUI);
        ins.i_j    = (op == OP_J);
        ins.i_jal  = (op == OP_JAL);
    end

    assign illegal = ~|ins;

endmodule

// File: rtl/mc_cu.sv
// Multi-cycle MIPS control unit: IF/ID/EXE/MEM/WB sequencer driving the shared
// datapath enables and mux selects, plus a retired-instruction counter.
import mc_cu_pkg::*;

module mc_cu #(
    parameter int MEM_WAIT_EN = 1,
    parameter int EXT_OPS     = 0,
    parameter int CNT_W       = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             z,
    input  logic             mem_ready,
    output logic             wpc,
    output logic             wir,
    output logic             wmem,
    output logic             wreg,
    output logic             iord,
    output logic             regrt,
    output logic             m2reg,
    output logic [3:0]       aluc,
    output logic             shift,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsource,
    output logic             sext,
    output logic             jal,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    state_t cur, nxt;
    instr_t ins;
    logic   dec_illegal, ready, done;
    logic   is_jump, is_branch, is_mem, is_shift, is_imm, is_itype_wb, taken, sext_op;
    logic   wpc_c, wir_c, wmem_c, wreg_c, illegal_c;
    logic [3:0] alu_op;

    mc_cu_dec #(.EXT_OPS(EXT_OPS)) u_dec (
        .op      (op),
        .func    (func),
        .ins     (ins),
        .illegal (dec_illegal)
    );

    // Memory handshake: an access issued in IF or MEM completes on the clock edge
    // where mem_ready is high; until then the state and all outputs hold steady.
    assign ready = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

    assign is_jump     = ins.i_j | ins.i_jr | ins.i_jal;
    assign is_branch   = ins.i_beq | ins.i_bne;
    assign is_mem      = ins.i_lw | ins.i_sw;
    assign is_shift    = ins.i_sll | ins.i_srl | ins.i_sra;
    assign is_itype_wb = ins.i_addi | ins.i_andi | ins.i_ori | ins.i_xori | ins.i_slti
                       | ins.i_lui | ins.i_lw;
    assign is_imm      = is_itype_wb | ins.i_sw;
    assign taken       = (ins.i_beq & z) | (ins.i_bne & ~z);
    assign sext_op     = ins.i_addi | ins.i_slti | is_mem | is_branch;

    always_comb begin
        alu_op = ALU_ADD;
        if (ins.i_add || ins.i_addi || is_mem)     alu_op = ALU_ADD;
        else if (ins.i_sub || is_branch)           alu_op = ALU_SUB;
        else if (ins.i_and || ins.i_andi)          alu_op = ALU_AND;
        else if (ins.i_or || ins.i_ori)            alu_op = ALU_OR;
        else if (ins.i_xor || ins.i_xori)          alu_op = ALU_XOR;
        else if (ins.i_lui)                        alu_op = ALU_LUI;
        else if (ins.i_sll)                        alu_op = ALU_SLL;
        else if (ins.i_srl)                        alu_op = ALU_SRL;
        else if (ins.i_sra)                        alu_op = ALU_SRA;
        else if (ins.i_slt || ins.i_slti)          alu_op = ALU_SLT;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cur <= S_IF;
        else       cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        case (cur)
            S_IF:  if (ready) nxt = S_ID;
            S_ID:  nxt = (dec_illegal || is_jump) ? S_IF : S_EXE;
            S_EXE: nxt = is_branch ? S_IF : (is_mem ? S_MEM : S_WB);
            S_MEM: if (ready) nxt = ins.i_sw ? S_IF : S_WB;
            S_WB:  nxt = S_IF;
            default: nxt = S_IF;
        endcase
    end

    always_comb begin
        wpc_c = 1'b0; wir_c = 1'b0; wmem_c = 1'b0; wreg_c = 1'b0; illegal_c = 1'b0;
        iord = 1'b0; regrt = 1'b0; m2reg = 1'b0; aluc = ALU_ADD; shift = 1'b0;
        alusrca = 1'b0; alusrcb = SRCB_RT; pcsource = PC_ALU; sext = 1'b0; jal = 1'b0;
        case (cur)
            S_IF: begin
                alusrcb = SRCB_FOUR;
                wpc_c   = ready;
                wir_c   = ready;
            end
            S_ID: begin
                // PC + (imm<<2) lands in the ALU result register for a later branch.
                alusrcb   = SRCB_BR;
                illegal_c = dec_illegal;
                if (ins.i_j || ins.i_jal) begin
                    wpc_c    = 1'b1;
                    pcsource = PC_JUMP;
                end
                if (ins.i_jr) begin
                    wpc_c    = 1'b1;
                    pcsource = PC_RS;
                end
                if (ins.i_jal) begin
                    wreg_c = 1'b1;
                    jal    = 1'b1;
                end
            end
            S_EXE: begin
                shift   = is_shift;
                alusrca = ~is_shift;
                alusrcb = is_imm ? SRCB_IMM : SRCB_RT;
                aluc    = alu_op;
                sext    = sext_op;
                if (is_branch && taken) begin
                    wpc_c    = 1'b1;
                    pcsource = PC_ALUOUT;
                end
            end
            S_MEM: begin
                iord   = 1'b1;
                wmem_c = ins.i_sw;
            end
            S_WB: begin
                wreg_c = 1'b1;
                regrt  = is_itype_wb;
                m2reg  = ins.i_lw;
            end
            default: ;
        endcase
    end

    // Write strobes are gated by reset so an aborted store drops wmem at once.
    assign wpc     = wpc_c & ~reset;
    assign wir     = wir_c & ~reset;
    assign wmem    = wmem_c & ~reset;
    assign wreg    = wreg_c & ~reset;
    assign illegal = illegal_c & ~reset;
    assign state   = cur;

    assign done = ((cur == S_ID) && is_jump) || ((cur == S_EXE) && is_branch)
               || ((cur == S_MEM) && ready && ins.i_sw) || (cur == S_WB);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)     retired <= '0;
        else if (done) retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
    end

endmodule
